pixel_stream_writer: RTL and testbench
======================================

PIXEL_STREAM_WRITER -- requirements
Module: pixel_stream_writer

Interface
REQ-001 SHALL have parameter RAM_SIZE, default 1024, giving the video cache depth in pixels (32x32 image).
REQ-002 SHALL have parameter COLOR_LEN, default 12, giving the pixel width in bits (4:4:4 RGB).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port in_ready, input, 1 bit: in_data is valid this cycle; one byte is consumed per asserted cycle, with no backpressure.
REQ-006 SHALL have port in_data, input, 8 bits: a payload byte from the RX packet path.
REQ-007 SHALL have port in_done, input, 1 bit: end of packet; meaningful with or without in_ready.
REQ-008 SHALL have port ram_write_req, output, 1 bit: a single-cycle write strobe to the video cache write port.
REQ-009 SHALL have port ram_write_addr, output, clog2(RAM_SIZE) bits: the pixel address {image_y, image_x}.
REQ-010 SHALL have port ram_write_val, output, COLOR_LEN bits: the pixel colour.
REQ-011 SHALL have port frame_done, output, 1 bit: a one-cycle pulse coinciding with the write to address RAM_SIZE-1.
REQ-012 SHALL have port short_pkt, output, 1 bit: a one-cycle pulse when a packet ends mid-header or mid-pixel.

Function
REQ-013 Packet format SHALL be: byte H0, then byte H1, then pixel bytes; start offset = {H0[1:0], H1}; H0[7:2] SHALL be ignored.
REQ-014 Pixel packing SHALL be 3 bytes -> 2 pixels: B0 = P0[11:4]; B1 = {P0[3:0], P1[11:8]}; B2 = P1[7:0].
REQ-015 The FSM SHALL have states HDR0, HDR1, PIX0, PIX1, PIX2; reset state is HDR0.
REQ-016 Transitions on in_ready=1 SHALL be: HDR0->HDR1; HDR1->PIX0 (address counter loaded with offset); PIX0->PIX1; PIX1->PIX2; PIX2->PIX0.
REQ-017 On a byte accepted in PIX1, the block SHALL write P0 at the current address, then increment the address.
REQ-018 On a byte accepted in PIX2, the block SHALL write P1 at the current address, then increment the address.
REQ-019 No write SHALL occur in HDR0, HDR1 or PIX0; at most one write occurs per input byte.
REQ-020 Write outputs SHALL be registered: ram_write_req/addr/val are valid the cycle after the accepting byte cycle.
REQ-021 The address SHALL wrap from RAM_SIZE-1 to 0 without error; frame_done SHALL pulse with every write to RAM_SIZE-1.
REQ-022 On in_done, the FSM SHALL return to HDR0 on the next edge; if in_ready is also set, that byte SHALL be processed first, including any write it triggers.
REQ-023 short_pkt SHALL pulse the cycle after in_done when the post-byte state is HDR1, PIX1 or PIX2; the held partial pixel SHALL be discarded.
REQ-024 in_done in HDR0 or PIX0 (post-byte) SHALL NOT pulse short_pkt.
REQ-025 in_data SHALL be ignored whenever in_ready=0; state SHALL hold.
REQ-026 ram_write_addr and ram_write_val SHALL hold their last value when ram_write_req=0.

Reset
REQ-027 Asserting rst low SHALL immediately force state=HDR0, address=0, ram_write_req=0, ram_write_addr=0, ram_write_val=0, frame_done=0, short_pkt=0.
REQ-028 Reset mid-packet SHALL discard all partial state; the first byte after release SHALL be treated as H0.
REQ-029 Outputs SHALL remain at reset values until the first accepted pixel byte after rst deasserts.

Verification
REQ-030 Bytes 0x00,0x05,0xAB,0xCD,0xEF then in_done -> writes (addr 5, 0xABC) then (addr 6, 0xDEF); no short_pkt.
REQ-031 Header offset 0x3FF (0x03,0xFF), then 6 pixel bytes -> writes at addr 1023, 0, 1, 2; frame_done pulses only with the addr-1023 write.
REQ-032 Header 0x00,0x00, then bytes 0x12,0x34 with in_done asserted alongside 0x34 -> one write (addr 0, 0x123); short_pkt pulses once; next packet starts at HDR0.
REQ-033 Bytes with in_ready toggling 1,0,1,0 and junk in_data on idle cycles -> results identical to back-to-back input; junk never written.
REQ-034 rst low during PIX1 of a packet, then a fresh packet 0x00,0x0A,0xFF,0xF0,0x00 -> single write pair (addr 10, 0xFFF), (addr 11, 0x000); no stale writes.
REQ-035 in_done alone in HDR0 -> no write, no short_pkt, state remains HDR0.

Source files
------------

// File: rtl/pixel_stream_writer.sv
// Unpacks a byte stream of {header offset, 3-bytes-per-2-pixels payload} into
// registered single-pixel writes for the video cache, with frame and short-packet flags.
//
// state | meaning
// HDR0  | waiting for header byte 0 (offset[9:8] in bits [1:0])
// HDR1  | waiting for header byte 1 (offset[7:0])
// PIX0  | waiting for B0 = P0[11:4]
// PIX1  | waiting for B1 = {P0[3:0], P1[11:8]}; writes P0
// PIX2  | waiting for B2 = P1[7:0]; writes P1
module pixel_stream_writer #(
  parameter int RAM_SIZE  = 1024,
  parameter int COLOR_LEN = 12
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_ready,
  input  logic [7:0]                  in_data,
  input  logic                        in_done,
  output logic                        ram_write_req,
  output logic [$clog2(RAM_SIZE)-1:0] ram_write_addr,
  output logic [COLOR_LEN-1:0]        ram_write_val,
  output logic                        frame_done,
  output logic                        short_pkt
);

  localparam int ADDR_W = $clog2(RAM_SIZE);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RAM_SIZE - 1);

  typedef enum logic [2:0] {HDR0, HDR1, PIX0, PIX1, PIX2} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_next;
  logic [1:0]        hdr_hi_q;
  logic [7:0]        b0_q;
  logic [3:0]        p1_hi_q;
  logic [9:0]        hdr_offset;
  logic [11:0]       pix;
  logic              wr_en;
  logic              short_d;

  assign hdr_offset = {hdr_hi_q, in_data};
  // Explicit wrap so non-power-of-two cache depths still roll over at RAM_SIZE-1.
  assign addr_next  = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;

  always_comb begin
    state_d = state_q;
    wr_en   = 1'b0;
    pix     = '0;
    if (in_ready) begin
      case (state_q)
        HDR0:    state_d = HDR1;
        HDR1:    state_d = PIX0;
        PIX0:    state_d = PIX1;
        PIX1: begin
          state_d = PIX2;
          wr_en   = 1'b1;
          pix     = {b0_q, in_data[7:4]};
        end
        PIX2: begin
          state_d = PIX0;
          wr_en   = 1'b1;
          pix     = {p1_hi_q, in_data};
        end
        default: state_d = HDR0;
      endcase
    end
    // Short packet is judged on the post-byte state, before forcing back to HDR0.
    short_d = in_done && (state_d == HDR1 || state_d == PIX1 || state_d == PIX2);
    if (in_done) state_d = HDR0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= HDR0;
      addr_q   <= '0;
      hdr_hi_q <= '0;
      b0_q     <= '0;
      p1_hi_q  <= '0;
    end else begin
      state_q <= state_d;
      if (in_ready) begin
        case (state_q)
          HDR0: hdr_hi_q <= in_data[1:0];
          HDR1: addr_q   <= ADDR_W'(hdr_offset);
          PIX0: b0_q     <= in_data;
          PIX1: begin
            p1_hi_q <= in_data[3:0];
            addr_q  <= addr_next;
          end
          PIX2: addr_q <= addr_next;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ram_write_req  <= 1'b0;
      ram_write_addr <= '0;
      ram_write_val  <= '0;
      frame_done     <= 1'b0;
      short_pkt      <= 1'b0;
    end else begin
      ram_write_req <= wr_en;
      frame_done    <= wr_en && (addr_q == LAST_ADDR);
      short_pkt     <= short_d;
      if (wr_en) begin
        ram_write_addr <= addr_q;
        ram_write_val  <= COLOR_LEN'(pix);
      end
    end
  end

endmodule

// File: tb/tb_pixel_stream_writer.sv
// Bench for pixel_stream_writer: directed packet scenarios plus random packets,
// compared cycle by cycle against a byte-count based packet model.
module tb_pixel_stream_writer;

  localparam int RAM_SIZE = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_ready = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_done = 1'b0;
  logic        ram_write_req;
  logic [9:0]  ram_write_addr;
  logic [11:0] ram_write_val;
  logic        frame_done;
  logic        short_pkt;

  int n_checks = 0;
  int n_fail   = 0;

  bit [7:0] pkt[$];
  int exp_req, exp_addr, exp_val, exp_fd, exp_short;

  pixel_stream_writer #(.RAM_SIZE(RAM_SIZE), .COLOR_LEN(12)) dut (
    .clk(clk), .rst(rst), .in_ready(in_ready), .in_data(in_data), .in_done(in_done),
    .ram_write_req(ram_write_req), .ram_write_addr(ram_write_addr),
    .ram_write_val(ram_write_val), .frame_done(frame_done), .short_pkt(short_pkt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".req"},   int'(ram_write_req),  exp_req);
    chk({tag, ".addr"},  int'(ram_write_addr), exp_addr);
    chk({tag, ".val"},   int'(ram_write_val),  exp_val);
    chk({tag, ".frame"}, int'(frame_done),     exp_fd);
    chk({tag, ".short"}, int'(short_pkt),      exp_short);
  endtask

  // Model: the packet is a list of bytes; pixel k is built from byte group k/2
  // and written at (offset + k) mod RAM_SIZE when its last contributing byte arrives.
  task automatic model_step(input bit rdy, input bit [7:0] data, input bit done);
    int n, g, idx, offset;
    bit [11:0] val;
    exp_req = 0; exp_fd = 0; exp_short = 0;
    if (rdy) begin
      pkt.push_back(data);
      n = pkt.size();
      if (n >= 4 && (n - 3) % 3 != 0) begin
        g      = (n - 3) / 3;
        offset = {pkt[0][1:0], pkt[1]};
        if ((n - 3) % 3 == 1) begin
          idx = 2 * g;
          val = {pkt[2 + 3*g], pkt[3 + 3*g][7:4]};
        end else begin
          idx = 2 * g + 1;
          val = {pkt[3 + 3*g][3:0], pkt[4 + 3*g]};
        end
        exp_req  = 1;
        exp_addr = (offset + idx) % RAM_SIZE;
        exp_val  = int'(val);
        exp_fd   = (exp_addr == RAM_SIZE - 1) ? 1 : 0;
      end
    end
    if (done) begin
      n = pkt.size();
      exp_short = (n == 1 || (n >= 2 && (n - 2) % 3 != 0)) ? 1 : 0;
      pkt.delete();
    end
  endtask

  task automatic drive(input bit rdy, input bit [7:0] data, input bit done, input string tag);
    @(negedge clk);
    in_ready = rdy;
    in_data  = data;
    in_done  = done;
    model_step(rdy, data, done);
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic idle(input string tag);
    drive(1'b0, 8'($urandom), 1'b0, tag);
  endtask

  task automatic reset_now(input string tag);
    @(negedge clk);
    rst = 1'b0;
    in_ready = 1'b0;
    in_done  = 1'b0;
    #1;
    pkt.delete();
    exp_req = 0; exp_addr = 0; exp_val = 0; exp_fd = 0; exp_short = 0;
    check_outputs(tag);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic send_pkt(input bit [7:0] bytes[$], input bit gaps, input bit done_with_last, input string tag);
    for (int i = 0; i < bytes.size(); i++) begin
      drive(1'b1, bytes[i], (done_with_last && i == bytes.size() - 1), tag);
      if (gaps) idle(tag);
    end
    if (!done_with_last) drive(1'b0, 8'($urandom), 1'b1, tag);
    idle(tag);
  endtask

  initial begin
    bit [7:0] b[$];
    exp_req = 0; exp_addr = 0; exp_val = 0; exp_fd = 0; exp_short = 0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs("reset");
    @(negedge clk);
    rst = 1'b1;
    idle("post_reset");

    b = '{8'h00, 8'h05, 8'hAB, 8'hCD, 8'hEF};
    send_pkt(b, 1'b0, 1'b0, "basic");

    b = '{8'h03, 8'hFF, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    send_pkt(b, 1'b0, 1'b0, "wrap");

    b = '{8'h00, 8'h00, 8'h12, 8'h34};
    send_pkt(b, 1'b0, 1'b1, "short");

    b = '{8'hFC, 8'h20, 8'hAB, 8'hCD, 8'hEF};
    send_pkt(b, 1'b1, 1'b0, "gapped");

    drive(1'b1, 8'h00, 1'b0, "mid_rst");
    drive(1'b1, 8'h40, 1'b0, "mid_rst");
    drive(1'b1, 8'h77, 1'b0, "mid_rst");
    reset_now("mid_rst");
    b = '{8'h00, 8'h0A, 8'hFF, 8'hF0, 8'h00};
    send_pkt(b, 1'b0, 1'b0, "after_rst");

    drive(1'b0, 8'hAA, 1'b1, "done_alone");
    idle("done_alone");
    b = '{8'h01, 8'h02, 8'h9A, 8'hBC, 8'hDE};
    send_pkt(b, 1'b0, 1'b0, "after_done");

    for (int p = 0; p < 200; p++) begin
      int len;
      bit done_last;
      b.delete();
      len = $urandom_range(0, 14);
      for (int i = 0; i < len; i++) b.push_back(8'($urandom));
      if (len >= 2 && $urandom_range(0, 3) == 0) begin
        b[0] = 8'h03;
        b[1] = 8'($urandom_range(8'hF0, 8'hFF));
      end
      done_last = (len > 0) && ($urandom_range(0, 1) == 1);
      for (int i = 0; i < len; i++) begin
        drive(1'b1, b[i], (done_last && i == len - 1), "rand");
        if ($urandom_range(0, 2) == 0) idle("rand");
      end
      if (!done_last) drive(1'b0, 8'($urandom), 1'b1, "rand");
      if ($urandom_range(0, 19) == 0) reset_now("rand_rst");
    end

    idle("final");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
